// File: rtl/queue_fifo.sv
// queue_fifo: parametrised single-clock FIFO with register-array storage.
// Extended pointers (one extra wrap bit) give exact full/empty/count. Writes
// and reads are protected, and misuse is latched in sticky overflow/underflow
// flags. FWFT selects a combinational (fall-through) or registered read port.
module queue_fifo #(
  parameter int WIDTH        = 14,
  parameter int DEPTH_LOG2   = 6,
  parameter int AFULL_THRESH = (1 << DEPTH_LOG2) - 4,
  parameter bit FWFT         = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      din,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic                  clr_err,
  output logic [WIDTH-1:0]      dout,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int AW    = DEPTH_LOG2;
  localparam int DEPTH = 1 << AW;
  localparam int CW    = AW + 1;
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_THRESH);

  // Pointers carry one extra wrap bit above the storage address.
  logic [AW:0]      wa_q, wa_d;
  logic [AW:0]      ra_q, ra_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  // Storage is deliberately left without reset.
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             empty_s;
  logic             full_s;
  logic [CW-1:0]    count_s;
  logic             wr_acc;
  logic             rd_acc;
  logic [AW-1:0]    waddr;
  logic [AW-1:0]    raddr;

  assign waddr = wa_q[AW-1:0];
  assign raddr = ra_q[AW-1:0];

  // Status decoded purely from registered pointers, so no request input
  // reaches empty/full/count/almost_full combinationally.
  always_comb begin
    empty_s = (wa_q == ra_q);
    full_s  = (wa_q[AW] != ra_q[AW]) && (waddr == raddr);
    count_s = wa_q - ra_q;
  end

  // Accept decisions and next-state for pointers and sticky error flags.
  always_comb begin
    rd_acc = rd_en && !empty_s;
    // A pop in the same cycle frees the slot, so a full FIFO still takes
    // a write when the read is also accepted.
    wr_acc = wr_en && (!full_s || rd_acc);

    wa_d  = wa_q;
    ra_d  = ra_q;
    ovf_d = ovf_q;
    unf_d = unf_q;

    if (wr_acc) begin
      wa_d = wa_q + 1'b1;
    end
    if (rd_acc) begin
      ra_d = ra_q + 1'b1;
    end

    // Clear first so that a coinciding new error event wins.
    if (clr_err) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (wr_en && !wr_acc) begin
      ovf_d = 1'b1;
    end
    if (rd_en && empty_s) begin
      unf_d = 1'b1;
    end
  end

  // Control state: pointers and sticky flags, asynchronously reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wa_q  <= '0;
      ra_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      wa_q  <= wa_d;
      ra_q  <= ra_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Storage write on every accepted write; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[waddr] <= din;
    end
  end

  generate
    if (FWFT) begin : g_fwft
      // Head entry is shown directly; only ra (a register) selects it.
      always_comb begin
        dout = mem_q[raddr];
      end
    end else begin : g_regread
      logic [WIDTH-1:0] dout_q, dout_d;

      // Load the head word on a pop, hold it otherwise.
      always_comb begin
        dout_d = dout_q;
        if (rd_acc) begin
          dout_d = mem_q[raddr];
        end
      end

      // Output register, cleared by reset so dout is 0 immediately.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dout_q <= '0;
        end else begin
          dout_q <= dout_d;
        end
      end

      assign dout = dout_q;
    end
  endgenerate

  assign empty       = empty_s;
  assign full        = full_s;
  assign count       = count_s;
  assign almost_full = (count_s >= AFULL_C);
  assign overflow    = ovf_q;
  assign underflow   = unf_q;

endmodule

// File: tb/tb_queue_fifo.sv
// Bench for queue_fifo: a fall-through instance (u1) and a registered-read
// instance (u0), both 14x64, compared against queue-based reference models.
module tb_queue_fifo;
  localparam int W  = 14;
  localparam int AL = 6;
  localparam int D  = 64;
  localparam int SW = AL + 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b1;

  logic [W-1:0] din1, dout1, din0, dout0;
  logic wr1 = 1'b0, rd1 = 1'b0, clr1 = 1'b0;
  logic wr0 = 1'b0, rd0 = 1'b0, clr0 = 1'b0;
  logic empty1, full1, af1, ovf1, unf1;
  logic empty0, full0, af0, ovf0, unf0;
  logic [AL:0] cnt1, cnt0;

  queue_fifo #(.WIDTH(W), .DEPTH_LOG2(AL), .AFULL_THRESH(D-4), .FWFT(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .din(din1), .wr_en(wr1), .rd_en(rd1), .clr_err(clr1),
    .dout(dout1), .empty(empty1), .full(full1), .almost_full(af1), .count(cnt1),
    .overflow(ovf1), .underflow(unf1));

  queue_fifo #(.WIDTH(W), .DEPTH_LOG2(AL), .AFULL_THRESH(D-4), .FWFT(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .din(din0), .wr_en(wr0), .rd_en(rd0), .clr_err(clr0),
    .dout(dout0), .empty(empty0), .full(full0), .almost_full(af0), .count(cnt0),
    .overflow(ovf0), .underflow(unf0));

  // Reference models: plain queues plus sticky error bits.
  logic [W-1:0] q1[$];
  logic [W-1:0] q0[$];
  bit movf1, munf1, movf0, munf0;
  logic [W-1:0] mdout0 = '0;

  int errors = 0;
  int checks = 0;

  function automatic logic [SW-1:0] exp_st1();
    int n = q1.size();
    return {(AL+1)'(n), n == 0, n == D, n >= D-4, movf1, munf1};
  endfunction

  function automatic logic [SW-1:0] exp_st0();
    int n = q0.size();
    return {(AL+1)'(n), n == 0, n == D, n >= D-4, movf0, munf0};
  endfunction

  // Advance both models by the inputs currently applied, then one clock.
  task automatic cycle();
    bit r_ok, w_ok;
    r_ok = rd1 && (q1.size() != 0);
    w_ok = wr1 && ((q1.size() != D) || r_ok);
    movf1 = (wr1 && !w_ok) ? 1'b1 : (clr1 ? 1'b0 : movf1);
    munf1 = (rd1 && q1.size() == 0) ? 1'b1 : (clr1 ? 1'b0 : munf1);
    if (r_ok) void'(q1.pop_front());
    if (w_ok) q1.push_back(din1);

    r_ok = rd0 && (q0.size() != 0);
    w_ok = wr0 && ((q0.size() != D) || r_ok);
    movf0 = (wr0 && !w_ok) ? 1'b1 : (clr0 ? 1'b0 : movf0);
    munf0 = (rd0 && q0.size() == 0) ? 1'b1 : (clr0 ? 1'b0 : munf0);
    if (r_ok) mdout0 = q0.pop_front();
    if (w_ok) q0.push_back(din0);

    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr1 = 0; rd1 = 0; clr1 = 0; wr0 = 0; rd0 = 0; clr0 = 0;
  endtask

  task automatic clear_models();
    q1.delete(); q0.delete();
    movf1 = 0; munf1 = 0; movf0 = 0; munf0 = 0; mdout0 = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    din1 = '0; din0 = '0;
    #2 rst_n = 1'b0;
    #1;
    clear_models();
    checks++;
    if ({cnt1, empty1, full1, af1, ovf1, unf1} !== exp_st1()) begin
      errors++; $display("FAIL reset_status1 got=%h exp=%h", {cnt1, empty1, full1, af1, ovf1, unf1}, exp_st1());
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({cnt0, empty0, full0, af0, ovf0, unf0} !== exp_st0()) begin
      errors++; $display("FAIL reset_status0 got=%h exp=%h", {cnt0, empty0, full0, af0, ovf0, unf0}, exp_st0());
    end
    checks++;
    if (dout0 !== '0) begin
      errors++; $display("FAIL reset_dout0 got=%h exp=0", dout0);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_fill();
    for (int i = 1; i <= D; i++) begin
      din1 = W'(i); wr1 = 1'b1;
      cycle();
      checks++;
      if ({cnt1, empty1, full1, af1, ovf1, unf1} !== exp_st1()) begin
        errors++; $display("FAIL fill_status i=%0d got=%h exp=%h", i, {cnt1, empty1, full1, af1, ovf1, unf1}, exp_st1());
      end
    end
    wr1 = 1'b0;
    checks++;
    if (af1 !== 1'b1 || full1 !== 1'b1 || cnt1 !== 7'd64) begin
      errors++; $display("FAIL fill_end af=%b full=%b cnt=%0d exp 1 1 64", af1, full1, cnt1);
    end
  endtask

  task automatic test_overflow();
    din1 = 14'h3FFF; wr1 = 1'b1;
    cycle();
    wr1 = 1'b0;
    checks++;
    if (ovf1 !== 1'b1 || cnt1 !== 7'd64) begin
      errors++; $display("FAIL overflow_set ovf=%b cnt=%0d exp 1 64", ovf1, cnt1);
    end
    clr1 = 1'b1;
    cycle();
    clr1 = 1'b0;
    checks++;
    if (ovf1 !== 1'b0 || {cnt1, empty1, full1, af1, ovf1, unf1} !== exp_st1()) begin
      errors++; $display("FAIL overflow_clr got=%h exp=%h", {cnt1, empty1, full1, af1, ovf1, unf1}, exp_st1());
    end
  endtask

  task automatic test_drain();
    for (int i = 1; i <= D; i++) begin
      checks++;
      if (dout1 !== W'(i)) begin
        errors++; $display("FAIL drain_dout i=%0d got=%h exp=%h", i, dout1, W'(i));
      end
      rd1 = 1'b1;
      cycle();
    end
    rd1 = 1'b0;
    checks++;
    if (empty1 !== 1'b1 || {cnt1, empty1, full1, af1, ovf1, unf1} !== exp_st1()) begin
      errors++; $display("FAIL drain_empty got=%h exp=%h", {cnt1, empty1, full1, af1, ovf1, unf1}, exp_st1());
    end
    rd1 = 1'b1;
    cycle();
    rd1 = 1'b0;
    checks++;
    if (unf1 !== 1'b1 || cnt1 !== 7'd0 || empty1 !== 1'b1) begin
      errors++; $display("FAIL underflow_set unf=%b cnt=%0d empty=%b exp 1 0 1", unf1, cnt1, empty1);
    end
    clr1 = 1'b1;
    cycle();
    clr1 = 1'b0;
    checks++;
    if (unf1 !== 1'b0) begin
      errors++; $display("FAIL underflow_clr got=%b exp=0", unf1);
    end
  endtask

  task automatic test_simultaneous();
    logic [W-1:0] w;
    for (int i = 0; i < D; i++) begin
      din1 = W'($urandom); wr1 = 1'b1;
      cycle();
    end
    din1 = W'($urandom); wr1 = 1'b1; rd1 = 1'b1;
    cycle();
    wr1 = 1'b0; rd1 = 1'b0;
    checks++;
    if (cnt1 !== 7'd64 || full1 !== 1'b1 || ovf1 !== 1'b0) begin
      errors++; $display("FAIL full_rw cnt=%0d full=%b ovf=%b exp 64 1 0", cnt1, full1, ovf1);
    end
    for (int i = 0; i < D; i++) begin
      checks++;
      if (dout1 !== q1[0]) begin
        errors++; $display("FAIL full_rw_drain i=%0d got=%h exp=%h", i, dout1, q1[0]);
      end
      rd1 = 1'b1;
      cycle();
    end
    w = W'($urandom);
    din1 = w; wr1 = 1'b1; rd1 = 1'b1;
    cycle();
    wr1 = 1'b0; rd1 = 1'b0;
    checks++;
    if (cnt1 !== 7'd1 || unf1 !== 1'b1 || dout1 !== w) begin
      errors++; $display("FAIL empty_rw cnt=%0d unf=%b dout=%h exp 1 1 %h", cnt1, unf1, dout1, w);
    end
    rd1 = 1'b1; clr1 = 1'b1;
    cycle();
    rd1 = 1'b0; clr1 = 1'b0;
  endtask

  task automatic test_stream();
    for (int i = 0; i < 300; i++) begin
      din1 = W'($urandom); wr1 = 1'b1; rd1 = 1'b1;
      cycle();
      checks++;
      if (cnt1 > 7'd1 || {cnt1, empty1, full1, af1, ovf1, unf1} !== exp_st1()) begin
        errors++; $display("FAIL stream_status i=%0d got=%h exp=%h", i, {cnt1, empty1, full1, af1, ovf1, unf1}, exp_st1());
      end
      checks++;
      if (dout1 !== q1[0]) begin
        errors++; $display("FAIL stream_order i=%0d got=%h exp=%h", i, dout1, q1[0]);
      end
    end
    wr1 = 1'b0; rd1 = 1'b1; clr1 = 1'b1;
    cycle();
    rd1 = 1'b0; clr1 = 1'b0;
  endtask

  task automatic test_random();
    int pw, pr;
    for (int ph = 0; ph < 6; ph++) begin
      pw = (ph % 2 == 0) ? 85 : 20;
      pr = (ph % 2 == 0) ? 25 : 80;
      for (int i = 0; i < 400; i++) begin
        din1 = W'($urandom);
        wr1  = ($urandom_range(99) < pw);
        rd1  = ($urandom_range(99) < pr);
        clr1 = ($urandom_range(99) < 4);
        cycle();
        checks++;
        if ({cnt1, empty1, full1, af1, ovf1, unf1} !== exp_st1()) begin
          errors++; $display("FAIL random_status ph=%0d i=%0d got=%h exp=%h", ph, i, {cnt1, empty1, full1, af1, ovf1, unf1}, exp_st1());
        end
        if (q1.size() != 0) begin
          checks++;
          if (dout1 !== q1[0]) begin
            errors++; $display("FAIL random_dout ph=%0d i=%0d got=%h exp=%h", ph, i, dout1, q1[0]);
          end
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_regread();
    din0 = 14'h0AAA; wr0 = 1'b1;
    cycle();
    wr0 = 1'b0;
    checks++;
    if (empty0 !== 1'b0 || dout0 !== 14'h0000) begin
      errors++; $display("FAIL regread_prepop empty=%b dout=%h exp 0 0000", empty0, dout0);
    end
    rd0 = 1'b1;
    cycle();
    rd0 = 1'b0;
    checks++;
    if (dout0 !== 14'h0AAA) begin
      errors++; $display("FAIL regread_pop got=%h exp=0aaa", dout0);
    end
    cycle();
    checks++;
    if (dout0 !== 14'h0AAA || empty0 !== 1'b1) begin
      errors++; $display("FAIL regread_hold dout=%h empty=%b exp 0aaa 1", dout0, empty0);
    end
    for (int i = 0; i < 600; i++) begin
      din0 = W'($urandom);
      wr0  = ($urandom_range(99) < ((i / 150) % 2 == 0 ? 80 : 30));
      rd0  = ($urandom_range(99) < ((i / 150) % 2 == 0 ? 30 : 80));
      clr0 = ($urandom_range(99) < 4);
      cycle();
      checks++;
      if ({cnt0, empty0, full0, af0, ovf0, unf0} !== exp_st0() || dout0 !== mdout0) begin
        errors++; $display("FAIL regread_random i=%0d st=%h exp=%h dout=%h exp=%h", i, {cnt0, empty0, full0, af0, ovf0, unf0}, exp_st0(), dout0, mdout0);
      end
    end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    logic [W-1:0] w;
    for (int i = 0; i < 5; i++) begin
      din1 = W'($urandom); wr1 = 1'b1;
      din0 = W'($urandom); wr0 = 1'b1; rd0 = (i > 1);
      cycle();
    end
    #2 rst_n = 1'b0;
    #1;
    clear_models();
    checks++;
    if ({cnt1, empty1, full1, af1, ovf1, unf1} !== exp_st1()) begin
      errors++; $display("FAIL async_rst1 got=%h exp=%h", {cnt1, empty1, full1, af1, ovf1, unf1}, exp_st1());
    end
    checks++;
    if (cnt0 !== 7'd0 || empty0 !== 1'b1 || dout0 !== '0) begin
      errors++; $display("FAIL async_rst0 cnt=%0d empty=%b dout=%h exp 0 1 0000", cnt0, empty0, dout0);
    end
    @(posedge clk);
    #1;
    checks++;
    if (cnt1 !== 7'd0 || empty1 !== 1'b1) begin
      errors++; $display("FAIL rst_held_write cnt=%0d empty=%b exp 0 1", cnt1, empty1);
    end
    idle_inputs();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    w = W'($urandom);
    din1 = w; wr1 = 1'b1;
    cycle();
    wr1 = 1'b0;
    checks++;
    if (cnt1 !== 7'd1 || dout1 !== w) begin
      errors++; $display("FAIL post_rst_write cnt=%0d dout=%h exp 1 %h", cnt1, dout1, w);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_simultaneous();
    test_stream();
    test_random();
    test_regread();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
